// File: rtl/weight_load_issuer_pkg.sv
// rtl/weight_load_issuer_pkg.sv - shared FSM encoding, beat geometry and weight address field map
package weight_load_issuer_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam int BEATS_PER_OC = 160;
    localparam int BEATS_3X3    = 144;
    localparam int IN_CH        = 16;

    localparam int WA_TYPE_BIT  = 31;
    localparam int WA_OC_HI     = 30;
    localparam int WA_OC_LO     = 23;
    localparam int WA_KOFF_HI   = 9;
    localparam int WA_KOFF_LO   = 6;
    localparam int WA_CH_HI     = 3;
    localparam int WA_CH_LO     = 0;

endpackage

// File: rtl/weight_load_issuer_addr_encode.sv
// rtl/weight_load_issuer_addr_encode.sv - combinational map of (beat, output channel) to weight write address
module weight_addr_encode
    import weight_load_issuer_pkg::*;
(
    input  logic [7:0]  i_beat,
    input  logic [7:0]  i_oc,
    output logic [31:0] o_waddr
);

    always_comb begin
        o_waddr = '0;
        o_waddr[WA_OC_HI:WA_OC_LO] = i_oc;
        if (i_beat < 8'(BEATS_3X3)) begin
            // 3x3 region: kernel offset is beat/IN_CH, input channel is beat%IN_CH
            o_waddr[WA_KOFF_HI:WA_KOFF_LO] = i_beat[7:4];
            o_waddr[WA_CH_HI:WA_CH_LO]     = i_beat[3:0];
        end else begin
            o_waddr[WA_TYPE_BIT]       = 1'b1;
            o_waddr[WA_CH_HI:WA_CH_LO] = 4'(i_beat - 8'(BEATS_3X3));
        end
    end

endmodule

// File: rtl/weight_load_issuer.sv
// rtl/weight_load_issuer.sv - issues weight read requests and forwards in-order responses to the MAC weight port
module weight_load_issuer #(
    parameter int MAX_OUTST    = 4,
    parameter int BEATS_PER_OC = weight_load_issuer_pkg::BEATS_PER_OC
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] cfg_base_addr,
    input  logic [7:0]  cfg_oc_base,
    input  logic [8:0]  cfg_oc_num,
    output logic        rd_req_valid,
    input  logic        rd_req_ready,
    output logic [31:0] rd_req_addr,
    input  logic        rd_rsp_valid,
    input  logic [31:0] rd_rsp_data,
    output logic [31:0] weight_waddr,
    output logic [31:0] weight_wdata,
    output logic        weight_wen,
    output logic        busy,
    output logic        done
);
    import weight_load_issuer_pkg::*;

    localparam int CNT_W = $clog2(BEATS_PER_OC * 256 + 1);
    localparam int OUT_W = $clog2(MAX_OUTST + 1);

    state_t            r_state;
    logic [31:0]       r_base;
    logic [7:0]        r_oc_cur;
    logic [CNT_W-1:0]  r_total;
    logic [CNT_W-1:0]  r_req_cnt;
    logic [CNT_W-1:0]  r_rsp_cnt;
    logic [OUT_W-1:0]  r_outst;
    logic [7:0]        r_beat;
    logic              r_busy;
    logic              r_done;
    logic              r_wen;
    logic [31:0]       r_waddr;
    logic [31:0]       r_wdata;

    logic              w_req_hs;
    logic              w_rsp_acc;
    logic              w_last_req;
    logic              w_last_rsp;
    logic [31:0]       w_waddr;

    assign rd_req_valid = (r_state == S_RUN) && (r_outst < OUT_W'(MAX_OUTST));
    assign rd_req_addr  = rd_req_valid ? (r_base + 32'({r_req_cnt, 2'b00})) : '0;

    assign w_req_hs   = rd_req_valid && rd_req_ready;
    // A response with nothing outstanding is a protocol error and is dropped
    assign w_rsp_acc  = rd_rsp_valid && (r_outst != '0);
    assign w_last_req = (r_req_cnt == r_total - 1'b1);
    assign w_last_rsp = (r_rsp_cnt == r_total - 1'b1);

    assign weight_wen   = r_wen;
    assign weight_waddr = r_waddr;
    assign weight_wdata = r_wdata;
    assign busy         = r_busy;
    assign done         = r_done;

    weight_addr_encode u_addr_encode (
        .i_beat  (r_beat),
        .i_oc    (r_oc_cur),
        .o_waddr (w_waddr)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_base    <= '0;
            r_oc_cur  <= '0;
            r_total   <= '0;
            r_req_cnt <= '0;
            r_rsp_cnt <= '0;
            r_outst   <= '0;
            r_beat    <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_wen     <= 1'b0;
            r_waddr   <= '0;
            r_wdata   <= '0;
        end else begin
            // Idle write port is held at zero so downstream beat detection never sees stale fields
            r_wen   <= w_rsp_acc;
            r_waddr <= w_rsp_acc ? w_waddr : '0;
            r_wdata <= w_rsp_acc ? rd_rsp_data : '0;

            if (w_req_hs != w_rsp_acc) begin
                r_outst <= w_req_hs ? r_outst + 1'b1 : r_outst - 1'b1;
            end
            if (w_req_hs) begin
                r_req_cnt <= r_req_cnt + 1'b1;
            end
            if (w_rsp_acc) begin
                r_rsp_cnt <= r_rsp_cnt + 1'b1;
                if (r_beat == 8'(BEATS_PER_OC - 1)) begin
                    r_beat   <= '0;
                    r_oc_cur <= r_oc_cur + 1'b1;
                end else begin
                    r_beat <= r_beat + 1'b1;
                end
            end

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_base    <= cfg_base_addr;
                        r_oc_cur  <= cfg_oc_base;
                        r_total   <= CNT_W'(cfg_oc_num) * CNT_W'(BEATS_PER_OC);
                        r_req_cnt <= '0;
                        r_rsp_cnt <= '0;
                        r_beat    <= '0;
                        r_busy    <= 1'b1;
                        if (cfg_oc_num == '0) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    if (w_req_hs && w_last_req) begin
                        r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (w_rsp_acc && w_last_rsp) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
